mem_bus_interconnect: RTL and testbench

//  Parametrised single-master, N-slave interconnect for the CPU mem_* valid/ready bus.

---
 rtl/bus_pkg.sv | 13 +
 rtl/bus_addr_decode.sv | 27 ++
 rtl/mem_bus_interconnect.sv | 150 +++++++++++++++
 tb/tb_mem_bus_interconnect.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared widths, FSM state type and select-width helper for the mem bus interconnect
package bus_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} bus_state_t;

   // A single-slave build still needs a 1-bit select register.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - combinational base/mask address decode with lowest-index priority
module bus_addr_decode
   import bus_pkg::*;
#(
   parameter int                             NUM_SLAVES = 3,
   parameter int                             SEL_W      = 2,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE = '0,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK = '0
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_hit,
   output logic [SEL_W-1:0]  o_idx
);

   // Scan from the top down so the lowest matching index is the one left standing.
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((i_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
            o_hit = 1'b1;
            o_idx = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/mem_bus_interconnect.sv
// rtl/mem_bus_interconnect.sv - single-master N-slave valid/ready interconnect with timeout and sticky error capture
module mem_bus_interconnect
   import bus_pkg::*;
#(
   parameter int                             NUM_SLAVES     = 3,
   parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE     = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK     = {3{32'hFFFF_0000}},
   parameter int                             TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         mem_valid,
   input  logic                         mem_instr,
   output logic                         mem_ready,
   input  logic [ADDR_W-1:0]            mem_addr,
   input  logic [DATA_W-1:0]            mem_wdata,
   input  logic [STRB_W-1:0]            mem_wstrb,
   output logic [DATA_W-1:0]            mem_rdata,
   output logic [NUM_SLAVES-1:0]        s_valid,
   output logic                         s_instr,
   input  logic [NUM_SLAVES-1:0]        s_ready,
   output logic [ADDR_W-1:0]            s_addr,
   output logic [DATA_W-1:0]            s_wdata,
   output logic [STRB_W-1:0]            s_wstrb,
   input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
   input  logic                         err_clear,
   output logic                         bus_err,
   output logic [ADDR_W-1:0]            err_addr
);

   localparam int SEL_W = sel_width(NUM_SLAVES);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   bus_state_t          r_state, w_next;
   logic [SEL_W-1:0]    r_sel;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic                r_instr;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_bus_err;
   logic [ADDR_W-1:0]   r_err_addr;

   logic                w_hit;
   logic [SEL_W-1:0]    w_idx;
   logic                w_sel_ready;
   logic [DATA_W-1:0]   w_sel_rdata;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic                w_timeout;
   logic                w_unmapped;
   logic                w_err_evt;
   logic [ADDR_W-1:0]   w_err_addr;

   bus_addr_decode #(
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_W      (SEL_W),
      .SLAVE_BASE (SLAVE_BASE),
      .SLAVE_MASK (SLAVE_MASK)
   ) u_decode (
      .i_addr (mem_addr),
      .o_hit  (w_hit),
      .o_idx  (w_idx)
   );

   assign w_sel_ready = s_ready[r_sel];
   assign w_sel_rdata = s_rdata[r_sel*DATA_W +: DATA_W];
   assign w_cnt_inc   = r_cnt + 1'b1;
   // A ready arriving on the final allowed cycle still completes normally.
   assign w_timeout   = (r_state == ACCESS) && !w_sel_ready && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
   assign w_unmapped  = (r_state == IDLE) && mem_valid && !w_hit;
   assign w_err_evt   = w_unmapped || w_timeout;
   assign w_err_addr  = w_unmapped ? mem_addr : r_addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (mem_valid) w_next = w_hit ? ACCESS : RESP;
         ACCESS:  if (w_sel_ready || w_timeout) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      mem_ready = (r_state == RESP);
      for (int i = 0; i < NUM_SLAVES; i++) begin
         s_valid[i] = (r_state == ACCESS) && (r_sel == SEL_W'(i));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_instr <= 1'b0;
         r_cnt   <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            IDLE: if (mem_valid) begin
               r_addr  <= mem_addr;
               r_wdata <= mem_wdata;
               r_wstrb <= mem_wstrb;
               r_instr <= mem_instr;
               r_sel   <= w_idx;
               r_cnt   <= '0;
               if (!w_hit) r_rdata <= (mem_wstrb == '0) ? ERR_RDATA : '0;
            end
            ACCESS: begin
               r_cnt <= w_cnt_inc;
               if (w_sel_ready)    r_rdata <= w_sel_rdata;
               else if (w_timeout) r_rdata <= (r_wstrb == '0) ? ERR_RDATA : '0;
            end
            default: ;
         endcase
      end
   end

   // A new error beats a simultaneous clear and reloads the address even if the flag was set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bus_err  <= 1'b0;
         r_err_addr <= '0;
      end else if (w_err_evt) begin
         r_bus_err <= 1'b1;
         if (!r_bus_err || err_clear) r_err_addr <= w_err_addr;
      end else if (err_clear) begin
         r_bus_err  <= 1'b0;
         r_err_addr <= '0;
      end
   end

   assign mem_rdata = r_rdata;
   assign s_addr    = r_addr;
   assign s_wdata   = r_wdata;
   assign s_wstrb   = r_wstrb;
   assign s_instr   = r_instr;
   assign bus_err   = r_bus_err;
   assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_mem_bus_interconnect.sv
// tb/tb_mem_bus_interconnect.sv - self-checking bench for mem_bus_interconnect against a transaction-level model
module tb_mem_bus_interconnect;

   localparam int          NS   = 3;
   localparam int          TOUT = 4;
   localparam logic [31:0] ERR  = 32'hDEAD_BEEF;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           mem_valid, mem_instr, mem_ready;
   logic [31:0]    mem_addr, mem_wdata, mem_rdata;
   logic [3:0]     mem_wstrb;
   logic [NS-1:0]  s_valid, s_ready;
   logic           s_instr;
   logic [31:0]    s_addr, s_wdata;
   logic [3:0]     s_wstrb;
   logic [NS*32-1:0] s_rdata;
   logic           err_clear, bus_err;
   logic [31:0]    err_addr;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
   logic [31:0] m_mask [NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};
   bit          m_err;
   logic [31:0] m_err_addr;

   mem_bus_interconnect #(
      .NUM_SLAVES     (NS),
      .SLAVE_BASE     ({32'h0000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SLAVE_MASK     ({32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
      .TIMEOUT_CYCLES (TOUT),
      .ERR_RDATA      (ERR)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_valid (mem_valid),
      .mem_instr (mem_instr),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .s_valid   (s_valid),
      .s_instr   (s_instr),
      .s_ready   (s_ready),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_rdata   (s_rdata),
      .err_clear (err_clear),
      .bus_err   (bus_err),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic int ref_sel(input logic [31:0] a);
      for (int i = 0; i < NS; i++)
         if ((a & m_mask[i]) == m_base[i]) return i;
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // lat: ACCESS cycle index on which the slave answers, -1 = never.
   task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] rd, input int lat, input bit hold, input bit clr);
      int          sel;
      bit          done;
      logic        instr;
      logic [31:0] exp_rd;
      sel   = ref_sel(addr);
      instr = 1'($urandom);
      s_rdata = {$urandom, $urandom, $urandom};
      if (sel >= 0) s_rdata[32*sel +: 32] = rd;
      mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_instr = instr;
      err_clear = clr;
      @(posedge clk); #1;
      err_clear = 1'b0;
      if (!hold) begin
         mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
      end
      if (sel < 0) begin
         if (!m_err || clr) m_err_addr = addr;
         m_err = 1'b1;
      end else if (clr) begin
         m_err = 1'b0; m_err_addr = '0;
      end
      if (sel < 0) begin
         check("unmapped_ready", 32'(mem_ready), 32'd1);
         check("unmapped_rdata", mem_rdata, (wstrb == 4'd0) ? ERR : 32'd0);
         check("unmapped_svalid", 32'(s_valid), 32'd0);
      end else begin
         done = 1'b0;
         for (int cyc = 0; cyc < TOUT && !done; cyc++) begin
            check("s_valid", 32'(s_valid), 32'd1 << sel);
            check("s_addr", s_addr, addr);
            check("s_wdata", s_wdata, wdata);
            check("s_wstrb_instr", {27'd0, s_instr, s_wstrb}, {27'd0, instr, wstrb});
            s_ready = NS'($urandom) & ~(NS'(1) << sel);
            if (cyc == lat) s_ready[sel] = 1'b1;
            @(posedge clk); #1;
            s_ready = '0;
            if (cyc == lat) begin
               done = 1'b1; exp_rd = rd;
            end else if (cyc + 1 == TOUT) begin
               done = 1'b1; exp_rd = (wstrb == 4'd0) ? ERR : 32'd0;
               if (!m_err) m_err_addr = addr;
               m_err = 1'b1;
            end
            if (done) begin
               check("resp_ready", 32'(mem_ready), 32'd1);
               check("resp_rdata", mem_rdata, exp_rd);
               check("resp_svalid", 32'(s_valid), 32'd0);
            end else begin
               check("wait_ready", 32'(mem_ready), 32'd0);
            end
         end
      end
      check("bus_err", 32'(bus_err), 32'(m_err));
      check("err_addr", err_addr, m_err_addr);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      check("ready_pulse", 32'(mem_ready), 32'd0);
      check("idle_svalid", 32'(s_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      int          lat;
      reset_n = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
      mem_wstrb = '0; s_ready = '0; s_rdata = '0; err_clear = 1'b0;
      m_err = 1'b0; m_err_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(mem_ready), 32'd0);
      check("rst_svalid", 32'(s_valid), 32'd0);
      check("rst_saddr", s_addr, 32'd0);
      check("rst_swdata", s_wdata, 32'd0);
      check("rst_sstrb_instr", {27'd0, s_instr, s_wstrb}, 32'd0);
      check("rst_rdata", mem_rdata, 32'd0);
      check("rst_err", 32'(bus_err), 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      do_txn(32'h0000_0010, 32'h0, 4'b0000, 32'h1234_5678, 2, 1'b0, 1'b0);
      do_txn(32'h1000_0000, 32'hA5, 4'b0001, $urandom, 0, 1'b0, 1'b0);
      do_txn(32'h3000_0000, 32'h0, 4'b0000, $urandom, -1, 1'b0, 1'b0);
      do_txn(32'h0100_0000, 32'h0, 4'b0000, $urandom, -1, 1'b0, 1'b0);
      do_txn(32'h4000_0000, 32'h0, 4'b0000, $urandom, -1, 1'b0, 1'b0);

      err_clear = 1'b1;
      @(posedge clk); #1;
      err_clear = 1'b0;
      m_err = 1'b0; m_err_addr = '0;
      check("clear_err", 32'(bus_err), 32'd0);
      check("clear_addr", err_addr, 32'd0);

      do_txn(32'h0000_1234, 32'h0, 4'b0000, $urandom, TOUT - 1, 1'b0, 1'b0);
      do_txn(32'h0200_0040, 32'h55AA, 4'b1111, $urandom, -1, 1'b0, 1'b0);
      do_txn(32'h5000_0000, 32'h77, 4'b0011, $urandom, -1, 1'b0, 1'b1);
      do_txn(32'h1000_0100, 32'h0, 4'b0000, $urandom, 1, 1'b1, 1'b0);

      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 3))
            0:       a = {16'h0000, 16'($urandom)};
            1:       a = {16'h1000, 16'($urandom)};
            2:       a = {4'h0, 28'($urandom)};
            default: a = {4'($urandom_range(2, 15)), 28'($urandom)};
         endcase
         lat = $urandom_range(0, TOUT);
         if (lat == TOUT) lat = -1;
         do_txn(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom), $urandom, lat,
                1'($urandom), ($urandom_range(0, 3) == 0));
      end

      mem_valid = 1'b1; mem_addr = 32'h0100_0000; mem_wstrb = '0; mem_wdata = '0;
      @(posedge clk); #1;
      mem_valid = 1'b0;
      check("pre_reset_svalid", 32'(s_valid), 32'd4);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      m_err = 1'b0; m_err_addr = '0;
      check("async_rst_svalid", 32'(s_valid), 32'd0);
      check("async_rst_ready", 32'(mem_ready), 32'd0);
      check("async_rst_err", 32'(bus_err), 32'd0);
      check("async_rst_saddr", s_addr, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      do_txn(32'h0000_0020, 32'h0, 4'b0000, 32'hCAFE_F00D, 1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
